// File: rtl/pong_pkg.sv
// ============================================================================
// Module : pong_pkg
// Brief  : Shared screen geometry defaults, colour constants and the render
//          FSM state type for the pong display path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  localparam logic COLOR_BLACK = 1'b0;
  localparam logic COLOR_WHITE = 1'b1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ERASE = 2'd2,
    ST_DRAW  = 2'd3
  } render_state_t;

  // True when a 12-bit pixel address lies inside the visible area.
  function automatic logic on_screen(input logic [11:0] x, input logic [11:0] y,
                                     input int w, input int h);
    return (x < 12'(w)) && (y < 12'(h));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ball_renderer_rect_scanner.sv
// ============================================================================
// Module : rect_scanner
// Brief  : Row-major offset generator for a width x height rectangle. The x
//          offset runs fastest; after the final offset the counters wrap to
//          (0,0) so the next rectangle starts clean without a restart input.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_scanner #(
  parameter int OFF_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_advance,
  input  logic [OFF_W-1:0] i_width,
  input  logic [OFF_W-1:0] i_height,
  output logic [OFF_W-1:0] o_x_off,
  output logic [OFF_W-1:0] o_y_off,
  output logic             o_last
);

  localparam logic [OFF_W-1:0] c_ONE = OFF_W'(1);

  logic [OFF_W-1:0] r_x_off;
  logic [OFF_W-1:0] r_y_off;
  logic             w_x_end;
  logic             w_y_end;

  assign w_x_end = (r_x_off == i_width  - c_ONE);
  assign w_y_end = (r_y_off == i_height - c_ONE);
  assign o_x_off = r_x_off;
  assign o_y_off = r_y_off;
  assign o_last  = w_x_end && w_y_end;

  // Step the offset pair in row-major order, wrapping to (0,0) after the last.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_off <= '0;
      r_y_off <= '0;
    end else if (i_advance) begin
      if (w_x_end) begin
        r_x_off <= '0;
        r_y_off <= w_y_end ? '0 : r_y_off + c_ONE;
      end else begin
        r_x_off <= r_x_off + c_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ball_renderer.sv
// ============================================================================
// Module : ball_renderer
// Brief  : Erases the ball square at its previous position and redraws it at
//          the new one through a pready-handshaked pixel write port.
//          Off-screen pixels are skipped in one cycle without a write.
//          Optional macro RENDER_CLEAR_EN: blank the whole screen after reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_renderer
  import pong_pkg::*;
#(
  parameter int BALL_SIZE = 4,
  parameter int SCREEN_W  = SCREEN_W_DEFAULT,
  parameter int SCREEN_H  = SCREEN_H_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic        pready,
  output logic [9:0]  px,
  output logic [8:0]  py,
  output logic        pcolor,
  output logic        pwrite,
  output logic        busy,
  output logic        frame_done
);

  localparam int               c_OFF_W = 10;
  localparam logic [c_OFF_W-1:0] c_BALL = c_OFF_W'(BALL_SIZE);
`ifdef RENDER_CLEAR_EN
  localparam render_state_t    c_RESET_STATE = ST_CLEAR;
`else
  localparam render_state_t    c_RESET_STATE = ST_IDLE;
`endif

  render_state_t      r_state;
  logic               r_drawn_valid;
  logic [10:0]        r_drawn_x;
  logic [10:0]        r_drawn_y;
  logic [10:0]        r_tgt_x;
  logic [10:0]        r_tgt_y;
  logic               r_frame_done;

  logic               w_in_pass;
  logic [10:0]        w_base_x;
  logic [10:0]        w_base_y;
  logic [c_OFF_W-1:0] w_scan_w;
  logic [c_OFF_W-1:0] w_scan_h;
  logic [c_OFF_W-1:0] w_x_off;
  logic [c_OFF_W-1:0] w_y_off;
  logic               w_last;
  logic [11:0]        w_ax;
  logic [11:0]        w_ay;
  logic               w_visible;
  logic               w_advance;
  logic               w_moved;

  rect_scanner #(
    .OFF_W (c_OFF_W)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .i_advance (w_advance),
    .i_width   (w_scan_w),
    .i_height  (w_scan_h),
    .o_x_off   (w_x_off),
    .o_y_off   (w_y_off),
    .o_last    (w_last)
  );

  // Select rectangle origin and size for the active pass, then form the address.
  always_comb begin
    w_base_x = 11'd0;
    w_base_y = 11'd0;
    case (r_state)
      ST_ERASE: begin
        w_base_x = r_drawn_x;
        w_base_y = r_drawn_y;
      end
      ST_DRAW: begin
        w_base_x = r_tgt_x;
        w_base_y = r_tgt_y;
      end
      default: begin
        w_base_x = 11'd0;
        w_base_y = 11'd0;
      end
    endcase
`ifdef RENDER_CLEAR_EN
    w_in_pass = (r_state != ST_IDLE);
    w_scan_w  = (r_state == ST_CLEAR) ? c_OFF_W'(SCREEN_W) : c_BALL;
    w_scan_h  = (r_state == ST_CLEAR) ? c_OFF_W'(SCREEN_H) : c_BALL;
`else
    w_in_pass = (r_state == ST_ERASE) || (r_state == ST_DRAW);
    w_scan_w  = c_BALL;
    w_scan_h  = c_BALL;
`endif
    w_ax      = {1'b0, w_base_x} + {2'b00, w_x_off};
    w_ay      = {1'b0, w_base_y} + {2'b00, w_y_off};
    w_visible = on_screen(w_ax, w_ay, SCREEN_W, SCREEN_H);
    // Off-screen pixels never wait for the framebuffer.
    w_advance = w_in_pass && (!w_visible || pready);
    w_moved   = !r_drawn_valid || (ball_x != r_drawn_x) || (ball_y != r_drawn_y);
  end

  // Outputs decode registered state; reset forces them quiet within the same cycle.
  assign pwrite     = !reset && w_in_pass && w_visible;
  assign px         = reset ? 10'd0 : w_ax[9:0];
  assign py         = reset ? 9'd0  : w_ay[8:0];
  assign pcolor     = reset ? COLOR_BLACK : ((r_state == ST_DRAW) ? COLOR_WHITE : COLOR_BLACK);
  assign busy       = reset || (r_state != ST_IDLE);
  assign frame_done = !reset && r_frame_done;

  // Render FSM: detect moves in IDLE, erase old square, draw new, report done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_RESET_STATE;
      r_drawn_valid <= 1'b0;
      r_drawn_x     <= 11'd0;
      r_drawn_y     <= 11'd0;
      r_tgt_x       <= 11'd0;
      r_tgt_y       <= 11'd0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_moved) begin
            r_tgt_x <= ball_x;
            r_tgt_y <= ball_y;
            r_state <= r_drawn_valid ? ST_ERASE : ST_DRAW;
          end
        end
        ST_ERASE: begin
          if (w_advance && w_last) r_state <= ST_DRAW;
        end
        ST_DRAW: begin
          if (w_advance && w_last) begin
            r_drawn_x     <= r_tgt_x;
            r_drawn_y     <= r_tgt_y;
            r_drawn_valid <= 1'b1;
            r_frame_done  <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
`ifdef RENDER_CLEAR_EN
          if (w_advance && w_last) r_state <= ST_IDLE;
`else
          r_state <= ST_IDLE;
`endif
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ball_renderer.sv
// ============================================================================
// Module : tb_ball_renderer
// Brief  : Scoreboard bench for ball_renderer (default build, 4x4 ball,
//          640x480 screen). Expected pixel writes and frame_done markers are
//          queued when a move is issued; a monitor pops and compares them.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_renderer;

  localparam int N = 4;
  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ball_x = 11'd0;
  logic [10:0] ball_y = 11'd0;
  logic        pready = 1'b1;
  logic [9:0]  px;
  logic [8:0]  py;
  logic        pcolor;
  logic        pwrite;
  logic        busy;
  logic        frame_done;

  ball_renderer #(.BALL_SIZE(N), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .pready     (pready),
    .px         (px),
    .py         (py),
    .pcolor     (pcolor),
    .pwrite     (pwrite),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fd;
    int x;
    int y;
    bit c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  int   m_x = 0;
  int   m_y = 0;
  bit   m_valid = 0;

  function automatic void check(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Reference model: every on-screen pixel of a square, row-major.
  function automatic void push_square(int bx, int by, bit c);
    exp_t e;
    for (int dy = 0; dy < N; dy++) begin
      for (int dx = 0; dx < N; dx++) begin
        if ((bx + dx) < W && (by + dy) < H) begin
          e.fd = 0; e.x = bx + dx; e.y = by + dy; e.c = c;
          q.push_back(e);
        end
      end
    end
  endfunction

  function automatic void push_pass(int nx, int ny);
    exp_t e;
    if (m_valid) push_square(m_x, m_y, 1'b0);
    push_square(nx, ny, 1'b1);
    e.fd = 1; e.x = 0; e.y = 0; e.c = 0;
    q.push_back(e);
    m_x = nx; m_y = ny; m_valid = 1;
  endfunction

  // Framebuffer ready: always, random, or the repeating 1,0,0,1 pattern.
  always @(posedge clk) begin
    cyc++;
    #1;
    case (rdy_mode)
      0: pready = 1'b1;
      1: pready = 1'($urandom_range(0, 1));
      default: pready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
  end

  // Monitor: compare accepted writes / frame_done against the queue head.
  bit       stall_prev = 0;
  int       s_px, s_py, s_pc;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_px", px, s_px);
        check("stall_py", py, s_py);
        check("stall_pcolor", pcolor, s_pc);
        check("stall_pwrite", pwrite, 1);
      end
      if (pwrite && pready) begin
        n_cmp++;
        if (q.size() == 0 || q[0].fd) begin
          n_err++;
          $display("FAIL unexpected_write: got (%0d,%0d,c=%0d) expected %s",
                   px, py, pcolor, (q.size() == 0) ? "no write" : "frame_done");
        end else begin
          e = q.pop_front();
          n_cmp--;
          check("pix_x", px, e.x);
          check("pix_y", py, e.y);
          check("pix_color", pcolor, e.c);
        end
      end
      if (frame_done) begin
        n_cmp++;
        if (q.size() == 0 || !q[0].fd) begin
          n_err++;
          $display("FAIL frame_done_order: got frame_done expected %0d more pixel(s)",
                   q.size());
        end else begin
          e = q.pop_front();
        end
      end
      stall_prev = pwrite && !pready;
      s_px = px; s_py = py; s_pc = pcolor;
    end
  end

  // Wait for frame_done, counting busy cycles; exp_cycles < 0 skips the count.
  task automatic wait_pass(input int exp_cycles);
    int nb = 0;
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (frame_done) done = 1;
    end
    if (!done) check("frame_done_timeout", 0, 1);
    else if (exp_cycles >= 0) check("busy_cycles", nb, exp_cycles);
  endtask

  task automatic move(input int x, input int y, input int exp_cycles);
    if (m_valid && x == m_x && y == m_y) begin
      repeat (4) @(posedge clk);
    end else begin
      push_pass(x, y);
      @(posedge clk); #1;
      ball_x = 11'(x); ball_y = 11'(y);
      wait_pass(exp_cycles);
    end
  endtask

  initial begin
    int rx, ry;
    // Reset state, with the first target already on the inputs.
    ball_x = 11'd20; ball_y = 11'd20;
    repeat (3) @(negedge clk);
    check("rst_pwrite", pwrite, 0);
    check("rst_px", px, 0);
    check("rst_py", py, 0);
    check("rst_pcolor", pcolor, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 1);
    // First pass after reset is draw only.
    push_pass(20, 20);
    @(posedge clk); #1; reset = 1'b0;
    wait_pass(16);
    // Full erase + draw with pready held high.
    move(21, 19, 32);
    // Stalling framebuffer during a pass.
    rdy_mode = 2;
    move(30, 25, -1);
    rdy_mode = 0;
    // Bottom-right corner: only four pixels are on screen.
    move(638, 478, 32);
    // Input changes during a pass: only the latest value is drawn afterwards.
    push_pass(100, 100);
    @(posedge clk); #1; ball_x = 11'd100; ball_y = 11'd100;
    repeat (5) @(posedge clk);
    #1; ball_x = 11'd30; ball_y = 11'd30;
    repeat (3) @(posedge clk);
    #1; ball_x = 11'd40; ball_y = 11'd40;
    push_pass(40, 40);
    wait_pass(-1);
    wait_pass(32);
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_queue_empty", q.size(), 0);
    // Reset in the middle of a pass.
    push_pass(200, 150);
    @(posedge clk); #1; ball_x = 11'd200; ball_y = 11'd150;
    repeat (6) @(posedge clk);
    #1; reset = 1'b1;
    @(negedge clk);
    check("midrst_pwrite", pwrite, 0);
    check("midrst_busy", busy, 1);
    q.delete();
    m_valid = 0;
    repeat (2) @(posedge clk);
    push_pass(200, 150);
    #1; reset = 1'b0;
    wait_pass(16);
    // Randomised moves, including edge-straddling positions, random pready.
    rdy_mode = 1;
    for (int k = 0; k < 25; k++) begin
      rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(630, 660)) : int'($urandom_range(0, 639));
      ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 490)) : int'($urandom_range(0, 479));
      move(rx, ry, -1);
    end
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    check("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
